// File: rtl/tff_updown_counter.sv
// Up/down binary counter built from pure toggle flip-flops (Q <= Q ^ T), with parallel
// load folded into the toggle mask. Optional activity accumulator: define TFF_ACTIVITY_EN.
module tff_updown_counter #(
  parameter int WIDTH = 8,
  parameter int ACT_W = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic             TC,
  output logic             WRAP,
  output logic [ACT_W-1:0] ACT,
  input  logic             ACT_CLR
);

  logic [WIDTH-1:0] cnt_mask;
  logic             run_up;
  logic             run_dn;

  // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred; blocking '=' is right here.
  always_comb begin
    cnt_mask = '0;
    run_up   = 1'b1;
    run_dn   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_mask[i] = UP ? run_up : run_dn;
      run_up      = run_up & Q[i];
      run_dn      = run_dn & ~Q[i];
    end
  end

  // Load is expressed as the mask that turns Q into D, so the state bits stay pure TFFs.
  always_comb begin
    T = '0;
    if (LD)     T = D ^ Q;
    else if (E) T = cnt_mask;
  end

  assign TC = UP ? (&Q) : ~(|Q);

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= Q ^ T;
      WRAP <= ~LD & E & TC;
    end
  end

`ifdef TFF_ACTIVITY_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((ACT_W > PC_W) ? ACT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] ACT_MAX = {{(SUM_W - ACT_W){1'b0}}, {ACT_W{1'b1}}};

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] act_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PC_W'(T[i]);
  end

  // Sum is one bit wider than either operand so the saturation compare never wraps.
  assign act_sum = SUM_W'(ACT) + SUM_W'(pop);

  always_ff @(posedge C or negedge R) begin
    if (!R)                     ACT <= '0;
    else if (ACT_CLR)           ACT <= '0;
    else if (act_sum > ACT_MAX) ACT <= '1;
    else                        ACT <= act_sum[ACT_W-1:0];
  end
`else
  logic unused_act_clr;

  assign ACT            = '0;
  assign unused_act_clr = ACT_CLR;
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboard bench for tff_updown_counter: stimulus pushes expectations from an arithmetic
// reference model, two monitors pop and compare combinational and registered outputs.
module tb_tff_updown_counter;
  localparam int WIDTH = 8;
  localparam int ACT_W = 4;
  localparam int unsigned MAX     = (1 << WIDTH) - 1;
  localparam int unsigned ACT_MAX = (1 << ACT_W) - 1;

  logic             C = 1'b0;
  logic             R = 1'b1;
  logic             E = 1'b0;
  logic             UP = 1'b0;
  logic             LD = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] T;
  logic             TC;
  logic             WRAP;
  logic [ACT_W-1:0] ACT;
  logic             ACT_CLR = 1'b0;

  tff_updown_counter #(.WIDTH(WIDTH), .ACT_W(ACT_W)) dut (
    .C(C), .R(R), .E(E), .UP(UP), .LD(LD), .D(D),
    .Q(Q), .T(T), .TC(TC), .WRAP(WRAP), .ACT(ACT), .ACT_CLR(ACT_CLR)
  );

  always #5 C = ~C;

  typedef struct { int unsigned t; bit tc; } comb_exp_t;
  typedef struct { int unsigned q; bit wrap; int unsigned act; } state_exp_t;

  comb_exp_t  comb_q[$];
  state_exp_t state_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_q   = 0;
  bit          m_wrap = 0;
  int unsigned m_act = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Combinational outputs are checked mid-low-phase, after inputs settle.
  initial begin
    comb_exp_t ce;
    forever begin
      @(negedge C);
      #2;
      if (comb_q.size() > 0) begin
        ce = comb_q.pop_front();
        check("T", 32'(T), 32'(ce.t));
        check("TC", 32'(TC), 32'(ce.tc));
      end
    end
  end

  // Registered outputs are checked just after the edge they were predicted for.
  initial begin
    state_exp_t se;
    forever begin
      @(posedge C);
      #1;
      if (state_q.size() > 0) begin
        se = state_q.pop_front();
        check("Q", 32'(Q), 32'(se.q));
        check("WRAP", 32'(WRAP), 32'(se.wrap));
        check("ACT", 32'(ACT), 32'(se.act));
      end
    end
  end

  // Reference model: the counter as an integer mod 2^WIDTH; T is whatever flips.
  task automatic step(input bit ld, input bit e, input bit up, input int unsigned d, input bit clr);
    int unsigned nq;
    int unsigned t;
    bit          tc;
    comb_exp_t   ce;
    state_exp_t  se;
    @(negedge C);
    LD = ld; E = e; UP = up; D = d[WIDTH-1:0]; ACT_CLR = clr;
    if (ld)      nq = d & MAX;
    else if (e)  nq = up ? ((m_q + 1) & MAX) : ((m_q + MAX) & MAX);
    else         nq = m_q;
    t  = m_q ^ nq;
    tc = up ? (m_q == MAX) : (m_q == 0);
    m_wrap = !ld && e && tc;
`ifdef TFF_ACTIVITY_EN
    if (clr) m_act = 0;
    else     m_act = (m_act + $countones(t) > ACT_MAX) ? ACT_MAX : m_act + $countones(t);
`else
    m_act = 0;
`endif
    m_q = nq;
    ce.t = t; ce.tc = tc;
    se.q = m_q; se.wrap = m_wrap; se.act = m_act;
    comb_q.push_back(ce);
    state_q.push_back(se);
  endtask

  // Asserts R between edges (after pending checks drain) and expects an immediate clear.
  task automatic do_reset(input int cycles);
    @(posedge C);
    #3;
    R = 1'b0;
    #1;
    check("reset_Q", 32'(Q), 32'd0);
    check("reset_WRAP", 32'(WRAP), 32'd0);
    check("reset_ACT", 32'(ACT), 32'd0);
    LD = 1'b0; E = 1'b0; ACT_CLR = 1'b0;
    m_q = 0; m_wrap = 0; m_act = 0;
    repeat (cycles) @(posedge C);
    #1;
    check("reset_hold_Q", 32'(Q), 32'd0);
    @(negedge C);
    R = 1'b1;
  endtask

  initial begin
    int unsigned d;
    int          r;
    #1 R = 1'b0;
    LD = 1'b0; E = 1'b0; ACT_CLR = 1'b0;
    repeat (3) @(posedge C);
    #1;
    check("init_Q", 32'(Q), 32'd0);
    check("init_WRAP", 32'(WRAP), 32'd0);
    check("init_ACT", 32'(ACT), 32'd0);
    @(negedge C);
    R = 1'b1;

    // Count up 0..5, then reset mid-count.
    repeat (5) step(0, 1, 1, 0, 0);
    do_reset(2);

    // Up wrap from a loaded 0xFE.
    step(1, 0, 1, 8'hFE, 0);
    repeat (3) step(0, 1, 1, 0, 0);

    // Down wrap through zero.
    step(1, 0, 0, 8'h00, 0);
    repeat (3) step(0, 1, 0, 0, 0);

    // Load priority over count, then load of the current value.
    step(1, 0, 1, 8'h3C, 0);
    step(1, 1, 1, 8'hA5, 0);
    step(1, 1, 0, 8'hA5, 0);
    // Load of the wrapped value never raises WRAP.
    step(1, 0, 1, 8'hFF, 0);
    step(1, 1, 1, 8'h00, 0);

    // Hold at 0x42.
    step(1, 0, 1, 8'h42, 0);
    for (int i = 0; i < 10; i++) step(0, 0, i[0], 0, 0);

    // Activity: fresh from reset, count to saturation, then clear.
    do_reset(1);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0);

    // Randomized traffic, biased toward wrap boundaries.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom_range(0, MAX);
      case ($urandom_range(0, 7))
        0: d = MAX;
        1: d = 0;
        2: d = MAX - 1;
        default: ;
      endcase
      step(r < 12, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, d,
           $urandom_range(0, 19) == 0);
      if (i == 200) do_reset(1);
    end

    @(posedge C);
    #3;
    check("drain_comb", 32'(comb_q.size()), 32'd0);
    check("drain_state", 32'(state_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
